mem_burst_arbiter: RTL and testbench
====================================

// Module: mem_burst_arbiter
// PURPOSE
// Arbitrates NUM_REQ cache controllers onto the single-ported main_memory and sequences each granted transaction.
// Each transaction is a burst of BURST_LEN beats, one 32-bit word per beat.
// Sits between the per-core cache FSMs and main_memory.
// Owns memory_request / memory_rw / memory_address and returns per-beat data or write acks to the winner.
// PARAMETERS
// NUM_REQ    4    number of requesters (2..8)
// BURST_LEN  4    beats per transaction; must match the memory burst length
// TIMEOUT    64   max cycles to wait for a mem_ready beat before abort
// PORTS
// clk        in   1            clock
// reset      in   1            asynchronous, active-high reset
// req_valid  in   NUM_REQ      per-requester request; held until its burst completes
// req_rw     in   NUM_REQ      1 = write, 0 = read; stable while req_valid
// req_addr   in   32*NUM_REQ   burst base byte address, slice i = [32*i+:32]; stable while req_valid
// req_wdata  in   32*NUM_REQ   current write beat data per requester
// grant      out  NUM_REQ      one-hot owner of the memory; zero when idle
// rsp_valid  out  NUM_REQ      one-cycle pulse: read beat on rsp_rdata, or write beat consumed
// rsp_last   out  1            qualifies rsp_valid; final beat of the burst
// rsp_rdata  out  32           read beat data, valid with rsp_valid
// rsp_err    out  NUM_REQ      one-cycle pulse: burst aborted on timeout
// mem_request out 1            one-cycle start pulse to memory
// mem_address out 32           burst base address, held during the burst
// mem_rw     out  1            held during the burst
// mem_data_in out 32           req_wdata slice of the granted requester (combinational mux on grant)
// mem_ready  in   1            memory beat strobe (memory_ready_to_interface)
// mem_data_out in 32           memory read data, valid with mem_ready
// BEHAVIOUR
// - Reset (async): all outputs 0, state IDLE, rr_ptr = 0, beat_cnt = 0, wd_cnt = 0.
//   Reset mid-burst abandons the burst; no rsp_valid or rsp_err is issued.
// - FSM: IDLE -> ISSUE -> BEAT -> DONE -> IDLE. A timeout in BEAT goes to DONE.
// - IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward, with wrap-around.
//   Register grant, and latch addr and rw into mem_address and mem_rw. Go to ISSUE.
//   Arbitration-to-grant latency is 1 cycle.
// - ISSUE: mem_request = 1 for exactly this cycle; beat_cnt = 0; go to BEAT.
// - BEAT, per cycle with mem_ready = 1:
//   - read: rsp_valid[g] = 1, rsp_rdata = mem_data_out, registered (1-cycle delay).
//   - write: rsp_valid[g] = 1 tells the requester the current req_wdata was taken.
//     The requester presents the next beat in the following cycle.
//   - beat_cnt increments. On beat BURST_LEN-1, rsp_last = 1 with that rsp_valid; go to DONE.
//   - mem_ready = 0 cycles are stalls; wd_cnt increments.
//   - wd_cnt clears on every mem_ready. If wd_cnt reaches TIMEOUT-1, pulse rsp_err[g] and go to DONE.
// - DONE: grant cleared; rr_ptr = (g+1) mod NUM_REQ; go to IDLE.
//   The requester must drop req_valid by this cycle, or it re-competes at the lowest priority.
// - Minimum burst occupancy is BURST_LEN+3 cycles. There is one idle cycle between back-to-back grants.
// - req_valid dropping mid-burst is ignored; the burst runs to completion.
// - Changes to the owner's req_addr or req_rw mid-burst are ignored (values are latched).
// - mem_ready outside BEAT is ignored and produces no rsp_valid.
// - Simultaneous requests: the rr_ptr scan order alone decides. There is no fixed priority beyond reset (rr_ptr = 0).
// - Non-owner rsp_valid, rsp_err and grant bits are always 0.
// TESTING
// - Single read: req_valid=0001, addr 0x100, memory gives 4 ready beats with D0..D3.
//   -> grant=0001 next cycle; one mem_request pulse with mem_address=0x100;
//   -> 4 rsp_valid[0] carrying D0..D3; rsp_last on D3.
// - Contention: req_valid=1111 held.
//   -> grants 0001, 0010, 0100, 1000, 0001 in order, each separated by a DONE/IDLE gap.
// - Write burst: req 2 writes 0xA..0xD, advancing wdata on each rsp_valid[2].
//   -> mem_data_in shows 0xA..0xD on successive mem_ready cycles; rsp_last on the 4th.
// - Stall/timeout: mem_ready held low for 63 cycles -> rsp_err[g] pulse; grant=0 two cycles later.
//   The same test with 62 stall cycles then a ready -> no error.
// - Reset at beat 2 of a read -> all outputs 0 immediately.
//   After release, req 3 alone -> grant=1000 (rr_ptr restarted at 0).

Source files
------------

// File: rtl/mem_burst_arbiter_if.sv
// Requester, response and main-memory signals of the burst arbiter.
// master = the arbiter itself, slave = the requester/memory side.
interface mem_burst_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_rw;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_last;
  logic [31:0]              rsp_rdata;
  logic [NUM_REQ-1:0]       rsp_err;
  logic                     mem_request;
  logic [31:0]              mem_address;
  logic                     mem_rw;
  logic [31:0]              mem_data_in;
  logic                     mem_ready;
  logic [31:0]              mem_data_out;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_data_out,
    output grant, rsp_valid, rsp_last, rsp_rdata, rsp_err,
           mem_request, mem_address, mem_rw, mem_data_in
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_data_out,
    input  grant, rsp_valid, rsp_last, rsp_rdata, rsp_err,
           mem_request, mem_address, mem_rw, mem_data_in
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter putting NUM_REQ cache controllers onto one burst memory port,
// sequencing each granted burst of BURST_LEN beats with a stall watchdog.
module mem_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input logic               clk,
  input logic               reset,
  mem_burst_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BEAT, DONE} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      rr_ptr, owner, pick;
  logic               pick_vld;
  logic [BW-1:0]      beat_cnt;
  logic [WW-1:0]      wd_cnt;
  logic [NUM_REQ-1:0] grant, rsp_valid, rsp_err;
  logic               rsp_last;
  logic [31:0]        rsp_rdata, mem_address;
  logic               mem_rw;
  logic               last_beat, wd_hit;

  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));
  // wd_cnt counts stalls already seen; this stall is the one that brings it to TIMEOUT-1
  assign wd_hit    = (wd_cnt == WW'(TIMEOUT - 2));

  // First requester at or after rr_ptr, with wrap; lowest offset wins as it is written last
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        pick     = IW'((int'(rr_ptr) + k) % NUM_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   state_nx = BEAT;
      BEAT:    if (bus.mem_ready ? last_beat : wd_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      wd_cnt      <= '0;
      grant       <= '0;
      rsp_valid   <= '0;
      rsp_err     <= '0;
      rsp_last    <= 1'b0;
      rsp_rdata   <= '0;
      mem_address <= '0;
      mem_rw      <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_last  <= 1'b0;
      unique case (state)
        IDLE: if (pick_vld) begin
          grant       <= NUM_REQ'(1) << pick;
          owner       <= pick;
          mem_address <= bus.req_addr[pick];
          mem_rw      <= bus.req_rw[pick];
        end
        ISSUE: begin
          beat_cnt <= '0;
          wd_cnt   <= '0;
        end
        BEAT: begin
          if (bus.mem_ready) begin
            rsp_valid <= grant;
            rsp_last  <= last_beat;
            if (!mem_rw) rsp_rdata <= bus.mem_data_out;
            beat_cnt  <= beat_cnt + 1'b1;
            wd_cnt    <= '0;
          end else if (wd_hit) begin
            rsp_err <= grant;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          grant  <= '0;
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_last    = rsp_last;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.mem_request = (state == ISSUE);
  assign bus.mem_address = mem_address;
  assign bus.mem_rw      = mem_rw;
  assign bus.mem_data_in = (|grant) ? bus.req_wdata[owner] : '0;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench: a memory model pushes expected beats, the monitor pops them
// as rsp_valid/rsp_err/grant appear. Everything is sampled on the falling edge.
module tb_mem_burst_arbiter;
  localparam int N = 4, BL = 4, TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.NUM_REQ(N)) bus ();
  mem_burst_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {logic [N-1:0] rv; logic last; logic rd; logic [31:0] data;} rsp_t;
  typedef struct {logic [N-1:0] g; logic [31:0] addr; logic rw; int gap;} gnt_t;

  rsp_t         rsp_q[$];
  gnt_t         gnt_q[$];
  logic [N-1:0] err_q[$];

  int checks = 0, errors = 0;

  logic [N-1:0] prev_grant;
  logic         prev_end, cur_rw, auto_drop, spurious;
  logic [31:0]  cur_addr;
  int           idle_run;
  int           wbeat[N];
  logic [31:0]  wbase[N];
  logic         m_act, m_rw, abort_cfg;
  int           m_beat, m_stall, stall_cfg;
  logic [31:0]  m_addr;
  logic [N-1:0] m_g;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    int r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a, input int b);
    return 32'hD000_0000 ^ (a << 4) ^ 32'(b);
  endfunction

  task automatic push_gnt(input int i, input logic [31:0] a, input logic rw, input int gap);
    gnt_q.push_back('{g: N'(1) << i, addr: a, rw: rw, gap: gap});
  endtask

  // One clock: monitor, requester model, then (after wdata settles) memory model
  task automatic tick();
    rsp_t        r;
    gnt_t        e;
    logic [31:0] d;
    @(negedge clk);
    if (bus.rsp_valid != '0 || bus.rsp_last) begin
      chk("rsp_owner", bus.rsp_valid & ~bus.grant, 0);
      if (rsp_q.size() == 0) chk("rsp_unexp", bus.rsp_valid, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_valid", bus.rsp_valid, r.rv);
        chk("rsp_last", bus.rsp_last, r.last);
        if (r.rd) chk("rsp_rdata", bus.rsp_rdata, r.data);
      end
    end
    if (bus.rsp_err != '0) begin
      if (err_q.size() == 0) chk("err_unexp", bus.rsp_err, 0);
      else chk("rsp_err", bus.rsp_err, err_q.pop_front());
    end
    if (prev_end) chk("grant_clr", bus.grant, 0);
    prev_end = bus.rsp_last || (bus.rsp_err != '0);
    if (bus.mem_request && bus.grant == '0) chk("mreq_idle", bus.mem_request, 0);
    if (bus.grant != '0 && prev_grant == '0) begin
      chk("mreq_with_grant", bus.mem_request, 1);
      if (gnt_q.size() == 0) chk("grant_unexp", bus.grant, 0);
      else begin
        e = gnt_q.pop_front();
        chk("grant", bus.grant, e.g);
        chk("mem_address", bus.mem_address, e.addr);
        chk("mem_rw", bus.mem_rw, e.rw);
        if (e.gap >= 0) chk("grant_gap", idle_run, e.gap);
      end
      cur_addr = bus.mem_address;
      cur_rw   = bus.mem_rw;
    end else if (bus.grant != '0) begin
      chk("addr_hold", bus.mem_address, cur_addr);
      chk("rw_hold", bus.mem_rw, cur_rw);
      chk("mreq_once", bus.mem_request, 0);
    end
    if (bus.grant == '0) idle_run++;
    else idle_run = 0;
    prev_grant = bus.grant;

    for (int i = 0; i < N; i++) begin
      if (bus.rsp_valid[i] && bus.req_rw[i]) wbeat[i]++;
      bus.req_wdata[i] = wbase[i] + 32'(wbeat[i]);
      if (auto_drop && ((bus.rsp_valid[i] && bus.rsp_last) || bus.rsp_err[i]))
        bus.req_valid[i] = 1'b0;
    end
    #1;
    bus.mem_ready = 1'b0;
    if (!m_act) begin
      if (bus.mem_request) begin
        m_act = 1'b1; m_beat = 0; m_stall = stall_cfg;
        m_addr = bus.mem_address; m_rw = bus.mem_rw; m_g = bus.grant;
      end else if (spurious) bus.mem_ready = 1'b1;
    end else if (m_stall > 0) begin
      m_stall--;
      if (m_stall == 0 && abort_cfg) begin
        err_q.push_back(m_g);
        m_act = 1'b0;
      end
    end else begin
      d = rd_word(m_addr, m_beat);
      bus.mem_ready    = 1'b1;
      bus.mem_data_out = d;
      if (m_rw) chk("mem_data_in", bus.mem_data_in, wbase[idx_of(m_g)] + 32'(m_beat));
      rsp_q.push_back('{rv: m_g, last: (m_beat == BL - 1), rd: !m_rw, data: d});
      m_beat++;
      if (m_beat == BL) m_act = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((rsp_q.size() != 0 || gnt_q.size() != 0 || err_q.size() != 0 || m_act ||
            bus.grant != '0) && n < max) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", 32'(n < max), 1);
  endtask

  task automatic clear_model();
    rsp_q.delete(); gnt_q.delete(); err_q.delete();
    m_act = 1'b0; prev_grant = '0; prev_end = 1'b0; idle_run = 0;
    for (int i = 0; i < N; i++) wbeat[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_data_out = '0;
    for (int i = 0; i < N; i++) wbase[i] = 32'h5000_0000 + 32'h100 * i;
    wbase[2] = 32'hA;
    stall_cfg = 0; abort_cfg = 1'b0; auto_drop = 1'b1; spurious = 1'b1;
    cur_addr = '0; cur_rw = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {bus.grant, bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.mem_request, bus.mem_rw}, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_wdata", bus.mem_data_in, 0);
    reset = 1'b0;
    tick();

    // Contention: all four held, strict rotation with one idle cycle between grants
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) bus.req_addr[i] = 32'h200 + 32'h1000 * i;
    for (int k = 0; k < 5; k++) push_gnt(k % N, 32'h200 + 32'h1000 * (k % N), 1'b0, (k == 0) ? -1 : 1);
    bus.req_valid = '1;
    n = 0;
    while (gnt_q.size() != 0 && n < 200) begin tick(); n++; end
    chk("contention_bound", 32'(n < 200), 1);
    bus.req_valid = '0;
    wait_idle(50);
    auto_drop = 1'b1;

    // Single read on req 0; addr/rw scribbled mid-burst must be ignored
    bus.req_addr[0] = 32'h100; bus.req_rw[0] = 1'b0;
    push_gnt(0, 32'h100, 1'b0, -1);
    bus.req_valid[0] = 1'b1;
    tick();
    chk("gnt_latency", bus.grant, 4'b0001);
    bus.req_addr[0] = 32'hDEAD_BEE0; bus.req_rw[0] = 1'b1;
    wait_idle(50);
    bus.req_rw[0] = 1'b0;

    // Write burst on req 2, wdata advancing on each rsp_valid
    bus.req_addr[2] = 32'h300; bus.req_rw[2] = 1'b1;
    push_gnt(2, 32'h300, 1'b1, -1);
    bus.req_valid[2] = 1'b1;
    wait_idle(50);
    chk("wbeats", 32'(wbeat[2]), 4);
    bus.req_rw[2] = 1'b0;

    // 62 stalls then data: no error
    stall_cfg = TO - 2;
    bus.req_addr[3] = 32'h400;
    push_gnt(3, 32'h400, 1'b0, -1);
    bus.req_valid[3] = 1'b1;
    wait_idle(200);

    // 63 stalls: abort with rsp_err
    stall_cfg = TO - 1; abort_cfg = 1'b1;
    bus.req_addr[1] = 32'h500;
    push_gnt(1, 32'h500, 1'b0, -1);
    bus.req_valid[1] = 1'b1;
    wait_idle(200);
    stall_cfg = 0; abort_cfg = 1'b0;

    // req_valid dropped right after grant: burst still completes
    bus.req_addr[1] = 32'h600;
    push_gnt(1, 32'h600, 1'b0, -1);
    bus.req_valid[1] = 1'b1;
    tick();
    bus.req_valid[1] = 1'b0;
    wait_idle(50);

    // Reset at beat 2 of a read on req 2 (rr_ptr is 2 here)
    bus.req_addr[2] = 32'h700;
    push_gnt(2, 32'h700, 1'b0, -1);
    bus.req_valid[2] = 1'b1;
    n = 0;
    while (!(m_act && m_beat == 2) && n < 50) begin tick(); n++; end
    chk("beat2_bound", 32'(n < 50), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", {bus.grant, bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.mem_request, bus.mem_rw}, 0);
    chk("mid_rst_addr", bus.mem_address, 0);
    chk("mid_rst_rdata", bus.rsp_rdata, 0);
    chk("mid_rst_wdata", bus.mem_data_in, 0);
    bus.req_valid = '0;
    clear_model();
    tick(); tick();
    reset = 1'b0;
    // rr_ptr back at 0: req 1 wins over req 3, then req 3
    bus.req_addr[1] = 32'h800; bus.req_addr[3] = 32'h900;
    push_gnt(1, 32'h800, 1'b0, -1);
    push_gnt(3, 32'h900, 1'b0, 1);
    bus.req_valid = 4'b1010;
    wait_idle(100);

    chk("rsp_q_left", rsp_q.size(), 0);
    chk("gnt_q_left", gnt_q.size(), 0);
    chk("err_q_left", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
